// File: rtl/uart_rx_loader.sv
// Serial boot loader: receives 8N1 bytes and writes framed 16-bit words into BSRAM.
// Frame: 0xA5, word count (0 = 256), lo/hi byte pairs, then an 8-bit additive checksum.
module uart_rx_loader #(
  parameter int CLKS_PER_BIT = 234,
  parameter int TIMEOUT_CLKS = 2_700_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        uart_rx,
  output logic [10:0] mem_ad,
  output logic [15:0] mem_din,
  output logic        mem_wre,
  output logic        busy,
  output logic        done,
  output logic        error
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_e;
  typedef enum logic [2:0] {L_IDLE, L_COUNT, L_LO, L_HI, L_WRITE, L_SUM} ld_state_e;

  // sync_q[1] is the synchronized line; sync_q[2] is its previous value for edge detection.
  logic [2:0] sync_q, sync_d;
  logic       rx_s, rx_fall;

  rx_state_e  r_state_q, r_state_d;
  logic [CW-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       byte_valid_q, byte_valid_d;
  logic       frame_err_q, frame_err_d;

  ld_state_e  l_state_q, l_state_d;
  logic [10:0] addr_q, addr_d;
  logic [8:0] remain_q, remain_d;
  logic [7:0] lo_q, lo_d;
  logic [7:0] sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [10:0] mem_ad_q, mem_ad_d;
  logic [15:0] mem_din_q, mem_din_d;
  logic       mem_wre_q, mem_wre_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       error_q, error_d;

  assign rx_s    = sync_q[1];
  assign rx_fall = sync_q[2] & ~sync_q[1];

  always_comb begin
    sync_d = {sync_q[1:0], uart_rx};
  end

  always_comb begin
    r_state_d    = r_state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        if (rx_fall) begin
          r_state_d = R_START;
          clk_cnt_d = '0;
          bit_cnt_d = '0;
        end
      end
      R_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          r_state_d = rx_s ? R_IDLE : R_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      R_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) r_state_d = R_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      R_STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d    = '0;
          byte_valid_d = rx_s;
          frame_err_d  = ~rx_s;
          r_state_d    = R_IDLE;
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin
    l_state_d = l_state_q;
    addr_d    = addr_q;
    remain_d  = remain_q;
    lo_d      = lo_q;
    sum_d     = sum_q;
    tmo_d     = '0;
    mem_ad_d  = mem_ad_q;
    mem_din_d = mem_din_q;
    mem_wre_d = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    error_d   = error_q;
    if (l_state_q != L_IDLE && !byte_valid_q) tmo_d = tmo_q + TW'(1);
    case (l_state_q)
      L_IDLE: begin
        if (byte_valid_q && shift_q == 8'hA5) begin
          l_state_d = L_COUNT;
          busy_d    = 1'b1;
          error_d   = 1'b0;
          addr_d    = '0;
          sum_d     = '0;
        end
      end
      L_COUNT: begin
        if (byte_valid_q) begin
          remain_d  = (shift_q == 8'd0) ? 9'd256 : {1'b0, shift_q};
          l_state_d = L_LO;
        end
      end
      L_LO: begin
        if (byte_valid_q) begin
          lo_d      = shift_q;
          sum_d     = sum_q + shift_q;
          l_state_d = L_HI;
        end
      end
      L_HI: begin
        // Write strobe is registered here so it is high exactly while in L_WRITE.
        if (byte_valid_q) begin
          sum_d     = sum_q + shift_q;
          mem_wre_d = 1'b1;
          mem_din_d = {shift_q, lo_q};
          mem_ad_d  = addr_q;
          l_state_d = L_WRITE;
        end
      end
      L_WRITE: begin
        addr_d    = addr_q + 11'd1;
        remain_d  = remain_q - 9'd1;
        l_state_d = (remain_q == 9'd1) ? L_SUM : L_LO;
      end
      L_SUM: begin
        if (byte_valid_q) begin
          done_d    = (shift_q == sum_q);
          error_d   = (shift_q != sum_q);
          busy_d    = 1'b0;
          l_state_d = L_IDLE;
        end
      end
      default: l_state_d = L_IDLE;
    endcase
    if (l_state_q != L_IDLE && (frame_err_q || tmo_q == TMO_LAST)) begin
      l_state_d = L_IDLE;
      busy_d    = 1'b0;
      error_d   = 1'b1;
      done_d    = 1'b0;
      mem_wre_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q       <= 3'b111;
      r_state_q    <= R_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      l_state_q    <= L_IDLE;
      addr_q       <= '0;
      remain_q     <= '0;
      lo_q         <= '0;
      sum_q        <= '0;
      tmo_q        <= '0;
      mem_ad_q     <= '0;
      mem_din_q    <= '0;
      mem_wre_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      sync_q       <= sync_d;
      r_state_q    <= r_state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      l_state_q    <= l_state_d;
      addr_q       <= addr_d;
      remain_q     <= remain_d;
      lo_q         <= lo_d;
      sum_q        <= sum_d;
      tmo_q        <= tmo_d;
      mem_ad_q     <= mem_ad_d;
      mem_din_q    <= mem_din_d;
      mem_wre_q    <= mem_wre_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign mem_ad  = mem_ad_q;
  assign mem_din = mem_din_q;
  assign mem_wre = mem_wre_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign error   = error_q;

endmodule

// File: tb/tb_uart_rx_loader.sv
// Directed and randomized serial loads checked against frames and expected writes
// built from the load protocol rules.
module tb_uart_rx_loader;

  localparam int CPB = 12;
  localparam int TMO = 3000;

  typedef logic [7:0]  bq_t[$];
  typedef logic [26:0] wq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        uart_rx = 1'b1;
  logic [10:0] mem_ad;
  logic [15:0] mem_din;
  logic        mem_wre;
  logic        busy;
  logic        done;
  logic        error;

  int total = 0;
  int bad = 0;
  wq_t wr_q;
  int done_cnt = 0;

  uart_rx_loader #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .uart_rx(uart_rx),
    .mem_ad(mem_ad), .mem_din(mem_din), .mem_wre(mem_wre),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Every cycle with the strobe high is one write; every cycle with done high is one pulse.
  always @(negedge clk) begin
    if (mem_wre) wr_q.push_back({mem_ad, mem_din});
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    uart_rx = 1'b0;
    idle(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      idle(CPB);
    end
    uart_rx = stop;
    idle(CPB);
    uart_rx = 1'b1;
    idle(CPB / 2);
  endtask

  task automatic send_seq(input bq_t s);
    foreach (s[i]) send_byte(s[i], 1'b1);
  endtask

  task automatic check_writes(input string tag, input wq_t exp);
    chk({tag, "_nwr"}, wr_q.size(), exp.size());
    for (int i = 0; i < exp.size() && i < wr_q.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i), {5'd0, wr_q[i]}, {5'd0, exp[i]});
  endtask

  // Frame for n random words (n = 256 sent as count byte 0), checksum optionally corrupted.
  task automatic make_load(input int n, input bit corrupt, output bq_t s, output wq_t w);
    logic [7:0]  sum;
    logic [15:0] word;
    s = {};
    w = {};
    sum = 8'd0;
    s.push_back(8'hA5);
    s.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      word = 16'($urandom);
      s.push_back(word[7:0]);
      s.push_back(word[15:8]);
      w.push_back({11'(i), word});
      sum = sum + word[7:0] + word[15:8];
    end
    s.push_back(corrupt ? (sum ^ 8'h5A) : sum);
  endtask

  task automatic run_load(input string tag, input int n, input bit corrupt);
    bq_t s;
    wq_t w;
    make_load(n, corrupt, s, w);
    wr_q.delete();
    done_cnt = 0;
    send_seq(s);
    idle(CPB);
    check_writes(tag, w);
    chk({tag, "_done"}, done_cnt, corrupt ? 0 : 1);
    chk({tag, "_error"}, error, corrupt);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ad_hold"}, mem_ad, n - 1);
  endtask

  initial begin
    bq_t s;
    wq_t w;

    // Reset values
    idle(5);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_wre", mem_wre, 0);
    chk("rst_ad", mem_ad, 0);
    chk("rst_din", mem_din, 0);
    rst_n = 1'b1;
    idle(CPB);

    // Two-word load with correct checksum
    wr_q.delete();
    done_cnt = 0;
    send_seq('{8'hA5, 8'h02});
    chk("two_busy_mid", busy, 1);
    send_seq('{8'h34, 8'h12, 8'h78, 8'h56, 8'h14});
    idle(CPB);
    check_writes("two", '{{11'd0, 16'h1234}, {11'd1, 16'h5678}});
    chk("two_done", done_cnt, 1);
    chk("two_error", error, 0);
    chk("two_busy", busy, 0);
    chk("two_din_hold", mem_din, 16'h5678);

    // Bad checksum: the write stays, error sticks until the next header
    wr_q.delete();
    done_cnt = 0;
    send_seq('{8'hA5, 8'h01, 8'h01, 8'h00, 8'hFF});
    idle(CPB);
    check_writes("badsum", '{{11'd0, 16'h0001}});
    chk("badsum_done", done_cnt, 0);
    chk("badsum_error", error, 1);
    send_seq('{8'h12, 8'h00});
    chk("sticky_error", error, 1);
    chk("sticky_busy", busy, 0);
    send_byte(8'hA5, 1'b1);
    chk("hdr_clears_error", error, 0);
    chk("hdr_sets_busy", busy, 1);
    send_seq('{8'h01, 8'hA5, 8'hA5, 8'h4A});
    idle(CPB);
    check_writes("a5data", '{{11'd0, 16'h0001}, {11'd0, 16'hA5A5}});
    chk("a5data_done", done_cnt, 1);

    // Short low glitch, then an ordinary byte while idle
    wr_q.delete();
    uart_rx = 1'b0;
    idle(4);
    uart_rx = 1'b1;
    idle(2 * CPB);
    send_byte(8'h55, 1'b1);
    idle(CPB);
    chk("glitch_nwr", wr_q.size(), 0);
    chk("glitch_busy", busy, 0);
    // Receiver still aligned: a full load works right after
    run_load("post_glitch", 1, 1'b0);

    // Framing error mid-load
    wr_q.delete();
    send_seq('{8'hA5, 8'h01});
    send_byte(8'h3C, 1'b0);
    idle(CPB);
    chk("frame_error", error, 1);
    chk("frame_busy", busy, 0);
    chk("frame_nwr", wr_q.size(), 0);

    // Idle line timeout mid-load
    wr_q.delete();
    send_seq('{8'hA5, 8'h03, 8'hAA});
    idle(TMO / 2);
    chk("tmo_busy_before", busy, 1);
    chk("tmo_error_before", error, 0);
    idle(TMO);
    chk("tmo_error", error, 1);
    chk("tmo_busy", busy, 0);
    chk("tmo_nwr", wr_q.size(), 0);

    // Reset in the middle of a load
    wr_q.delete();
    send_seq('{8'hA5, 8'h02, 8'h34, 8'h12});
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(CPB);
    chk("midrst_busy", busy, 0);
    chk("midrst_ad", mem_ad, 0);
    send_seq('{8'h78, 8'h56, 8'h14});
    idle(CPB);
    check_writes("midrst", '{{11'd0, 16'h1234}});
    chk("midrst_busy_after", busy, 0);

    // Randomized loads
    for (int k = 0; k < 3; k++)
      run_load($sformatf("rnd%0d", k), 1 + int'($urandom_range(3)), bit'($urandom_range(1)));

    // Full 256-word load
    run_load("full", 256, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx_loader.md
UART_RX_LOADER -- requirements
Module: uart_rx_loader

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 234, meaning clk cycles per UART bit (27 MHz / 115200).
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 2_700_000, meaning max idle clk cycles between bytes of one load (100 ms).
REQ-003 SHALL have port clk  input  1  system clock; all logic on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port uart_rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 SHALL have port mem_ad  output  11  BSRAM write address.
REQ-007 SHALL have port mem_din  output  16  BSRAM write data.
REQ-008 SHALL have port mem_wre  output  1  BSRAM write strobe, one cycle per word.
REQ-009 SHALL have port busy  output  1  high while a load is in progress (top holds the CPU and muxes mem_ad onto the BSRAM).
REQ-010 SHALL have port done  output  1  one-cycle pulse on successful load.
REQ-011 SHALL have port error  output  1  sticky load-failure flag.

Function
REQ-012 SHALL pass uart_rx through a 2-FF synchronizer, reset value 1, before any use.
REQ-013 Receiver SHALL run states R_IDLE, R_START, R_DATA, R_STOP.
REQ-014 R_IDLE: on synchronized falling edge -> R_START, bit counter cleared.
REQ-015 R_START: sample at CLKS_PER_BIT/2 cycles; low -> R_DATA; high -> R_IDLE as a glitch, no byte.
REQ-016 R_DATA: sample every CLKS_PER_BIT cycles from the start mid-point, 8 bits LSB first into a shift register, then -> R_STOP.
REQ-017 R_STOP: sample after CLKS_PER_BIT; high -> internal byte_valid pulse for one cycle with the byte; low -> framing error, byte dropped; either outcome -> R_IDLE.
REQ-018 Loader SHALL run states L_IDLE, L_COUNT, L_LO, L_HI, L_WRITE, L_SUM.
REQ-019 L_IDLE: byte 0xA5 -> L_COUNT, busy=1, error cleared, address counter=0, checksum=0; all other bytes ignored.
REQ-020 L_COUNT: byte N = word count, 0 meaning 256; store it, -> L_LO.
REQ-021 L_LO: store low byte, -> L_HI; L_HI: store high byte, -> L_WRITE.
REQ-022 L_WRITE: exactly one cycle with mem_wre=1, mem_din={hi,lo}, mem_ad=address counter; then increment the address counter and decrement the remaining count; remaining >0 -> L_LO, else -> L_SUM.
REQ-023 Checksum SHALL be the 8-bit wrap-around sum of all data bytes (lo and hi), excluding header and count.
REQ-024 L_SUM: received byte equals checksum -> done pulse one cycle, busy=0; mismatch -> error=1, busy=0; either -> L_IDLE.
REQ-025 Words already written SHALL stay written on checksum mismatch; no rollback.
REQ-026 Framing error while busy SHALL abort the load: error=1, busy=0, -> L_IDLE.
REQ-027 No byte for TIMEOUT_CLKS cycles while busy (counter restarted by each byte_valid) SHALL abort the load: error=1, busy=0, -> L_IDLE.
REQ-028 mem_wre SHALL be 0 in every state except L_WRITE; mem_ad/mem_din SHALL hold their last values when mem_wre=0.
REQ-029 Address counter SHALL be 11 bits; maximum address used is 255, so no wrap occurs.
REQ-030 A new 0xA5 header is only recognized in L_IDLE; 0xA5 as a data byte is treated as data.

Reset
REQ-031 rst_n low SHALL force R_IDLE, L_IDLE, synchronizer=1, mem_ad=0, mem_din=0, mem_wre=0, busy=0, done=0, error=0, all counters 0.
REQ-032 Reset asserted mid-load SHALL abandon the load with no further writes; previously written words are unaffected.

Verification
REQ-033 Send A5 02 34 12 78 56 14 -> mem_wre pulses at ad=0 din=0x1234, ad=1 din=0x5678, then done pulse, error=0, busy=0.
REQ-034 Send A5 01 01 00 FF -> one write ad=0 din=0x0001, no done, error=1 sticky until the next A5.
REQ-035 Send 8 clk-cycle low glitch, then 0x55 -> no byte_valid on the glitch, no writes, busy stays 0.
REQ-036 Send A5 01 then a byte with stop bit=0 -> error=1, busy=0, no writes.
REQ-037 Send A5 03 AA, then line idle > TIMEOUT_CLKS -> error=1, busy=0, no writes.
REQ-038 Send A5 00 + 256 words + correct sum -> 256 writes at ad 0..255, done pulse.
